// File: rtl/anubis_round_ctrl.sv
// Anubis round sequencer: whitening, ROUNDS datapath iterations with round-key add, result handshake.
// Optional abort input enabled by defining ANUBIS_ABORT_EN.
module anubis_round_ctrl #(
    parameter int unsigned ROUNDS     = 12,
    parameter int unsigned DP_LATENCY = 0,
    parameter int unsigned RIDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    output logic [RIDX_W-1:0] round_idx,
    input  logic [127:0]      rk_in,
    output logic [127:0]      dp_in,
    output logic              dp_last,
    input  logic [127:0]      dp_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out
`ifdef ANUBIS_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [BLK_W-1:0]  state_q, state_d;
    logic [RIDX_W-1:0] rnd_q, rnd_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [RIDX_W-1:0] round_idx_q, round_idx_d;
    logic              dp_last_q, dp_last_d;
    logic              abort_c;

`ifdef ANUBIS_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Next-state logic; dp_out and rk_in only reach state_d on capture cycles.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        rnd_d      = rnd_q;
        wait_cnt_d = wait_cnt_q;

        unique case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = data_in ^ rk_in;
                    rnd_d      = RIDX_W'(1);
                    wait_cnt_d = '0;
                    fsm_d      = RUN;
                end
            end
            RUN: begin
                if (wait_cnt_q == WCNT_W'(DP_LATENCY)) begin
                    state_d    = dp_out ^ rk_in;
                    wait_cnt_d = '0;
                    if (rnd_q == RIDX_W'(ROUNDS)) begin
                        fsm_d = DONE;
                    end else begin
                        rnd_d = rnd_q + RIDX_W'(1);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                    rnd_d = '0;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        if (abort_c && (fsm_q != IDLE)) begin
            fsm_d      = IDLE;
            state_d    = '0;
            rnd_d      = '0;
            wait_cnt_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with fsm_q.
    always_comb begin
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        round_idx_d = (fsm_d == RUN) ? rnd_d : '0;
        dp_last_d   = (fsm_d == RUN) && (rnd_d == RIDX_W'(ROUNDS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            wait_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            round_idx_q <= '0;
            dp_last_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            wait_cnt_q  <= wait_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            round_idx_q <= round_idx_d;
            dp_last_q   <= dp_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign round_idx = round_idx_q;
    assign dp_last   = dp_last_q;
    assign dp_in     = state_q;
    assign data_out  = state_q;

endmodule

// File: tb/tb_anubis_round_ctrl.sv
// Bench for anubis_round_ctrl: two instances (DP_LATENCY 0 and 2) checked against a block-level cipher model.
module tb_anubis_round_ctrl;

    localparam int unsigned ROUNDS = 12;
    localparam int unsigned RIDX_W = 4;
    localparam int unsigned N      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid  [N];
    logic              in_ready  [N];
    logic [127:0]      data_in   [N];
    logic [RIDX_W-1:0] round_idx [N];
    logic [127:0]      rk_in     [N];
    logic [127:0]      dp_in     [N];
    logic              dp_last   [N];
    logic [127:0]      dp_out    [N];
    logic              out_valid [N];
    logic              out_ready [N];
    logic [127:0]      data_out  [N];
`ifdef ANUBIS_ABORT_EN
    logic              abort     [N];
`endif

    logic [127:0] key [16];
    logic         ident;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        anubis_round_ctrl #(
            .ROUNDS    (ROUNDS),
            .DP_LATENCY((g == 0) ? 0 : 2),
            .RIDX_W    (RIDX_W)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .data_in  (data_in[g]),
            .round_idx(round_idx[g]),
            .rk_in    (rk_in[g]),
            .dp_in    (dp_in[g]),
            .dp_last  (dp_last[g]),
            .dp_out   (dp_out[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
`ifdef ANUBIS_ABORT_EN
            .abort    (abort[g]),
`endif
            .data_out (data_out[g])
        );
        // Key-schedule and round-datapath stand-ins
        assign rk_in[g]  = key[round_idx[g]];
        assign dp_out[g] = ident ? dp_in[g]
                         : (dp_last[g] ? ~dp_in[g] : {dp_in[g][119:0], dp_in[g][127:120]});
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Whole-block reference: whitening, then ROUNDS rounds, last round with the bypass variant.
    function automatic logic [127:0] model(input logic [127:0] din);
        logic [127:0] s;
        s = din ^ key[0];
        for (int r = 1; r <= int'(ROUNDS); r++) begin
            if (!ident) s = (r == int'(ROUNDS)) ? ~s : {s[119:0], s[127:120]};
            s = s ^ key[r];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < int'(N); i++) begin
            check({tag, "_in_ready"},  128'(in_ready[i]),  128'(0));
            check({tag, "_out_valid"}, 128'(out_valid[i]), 128'(0));
            check({tag, "_round_idx"}, 128'(round_idx[i]), 128'(0));
            check({tag, "_dp_last"},   128'(dp_last[i]),   128'(0));
            check({tag, "_data_out"},  data_out[i],        128'(0));
        end
    endtask

    task automatic set_spec_keys();
        for (int r = 0; r < 16; r++) key[r] = {16{8'(r)}};
    endtask

    task automatic set_random_keys();
        for (int r = 0; r < 16; r++) key[r] = rnd128();
    endtask

    // Runs one block through instance i from a negedge where it is idle; ends at a negedge, idle again.
    task automatic run_block(input int i, input logic [127:0] din, input int stall,
                             input logic use_c, input logic [127:0] exp_c);
        int           lat;
        int           total;
        int           rexp;
        logic [127:0] exp;
        lat   = (i == 0) ? 0 : 2;
        total = int'(ROUNDS) * (lat + 1) + 1;
        exp   = model(din);
        for (int k = 0; k < 20 && !in_ready[i]; k++) @(negedge clk);
        check("accept_ready", 128'(in_ready[i]), 128'(1));
        in_valid[i]  = 1'b1;
        data_in[i]   = din;
        out_ready[i] = 1'b0;
        @(negedge clk);
        for (int k = 1; k < total; k++) begin
            rexp = (k - 1) / (lat + 1) + 1;
            check("run_round_idx", 128'(round_idx[i]), 128'(rexp));
            check("run_dp_last",   128'(dp_last[i]),   128'(rexp == int'(ROUNDS)));
            check("run_in_ready",  128'(in_ready[i]),  128'(0));
            check("run_out_valid", 128'(out_valid[i]), 128'(0));
            data_in[i] = rnd128();
            @(negedge clk);
        end
        check("done_out_valid", 128'(out_valid[i]), 128'(1));
        check("done_data_out",  data_out[i],        exp);
        check("done_round_idx", 128'(round_idx[i]), 128'(0));
        if (use_c) check("done_spec_value", data_out[i], exp_c);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_out_valid", 128'(out_valid[i]), 128'(1));
            check("stall_data_out",  data_out[i],        exp);
            check("stall_in_ready",  128'(in_ready[i]),  128'(0));
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        check("post_out_valid", 128'(out_valid[i]), 128'(0));
        check("post_in_ready",  128'(in_ready[i]),  128'(1));
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b0;
    endtask

    initial begin
        ident = 1'b1;
        set_spec_keys();
        rst_n = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            in_valid[i]  = 1'b0;
            data_in[i]   = '0;
            out_ready[i] = 1'b0;
`ifdef ANUBIS_ABORT_EN
            abort[i]     = 1'b0;
`endif
        end

        // Reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                in_valid[i]  = 1'($urandom);
                data_in[i]   = rnd128();
                out_ready[i] = 1'($urandom);
            end
            @(negedge clk);
            check_reset_outputs("reset");
        end
        for (int i = 0; i < int'(N); i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready0", 128'(in_ready[0]), 128'(1));
        check("release_ready1", 128'(in_ready[1]), 128'(1));

        // Directed reference pattern, with and without backpressure
        run_block(0, 128'(0), 5, 1'b1, {16{8'h0C}});
        run_block(0, 128'(0), 0, 1'b1, {16{8'h0C}});
        run_block(1, 128'(0), 2, 1'b1, {16{8'h0C}});

        // Reset in the middle of a block
        in_valid[0] = 1'b1;
        data_in[0]  = rnd128();
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_ready", 128'(in_ready[0]), 128'(1));
        run_block(0, 128'(0), 1, 1'b1, {16{8'h0C}});

        // Randomized keys, data, datapath shape and backpressure
        for (int t = 0; t < 8; t++) begin
            ident = 1'($urandom);
            set_random_keys();
            run_block(int'($urandom_range(0, 1)), rnd128(), int'($urandom_range(0, 3)), 1'b0, '0);
        end

`ifdef ANUBIS_ABORT_EN
        // Abort during RUN
        ident = 1'b0;
        set_random_keys();
        in_valid[0] = 1'b1;
        data_in[0]  = rnd128();
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("abort_in_ready",  128'(in_ready[0]),  128'(1));
        check("abort_out_valid", 128'(out_valid[0]), 128'(0));
        check("abort_round_idx", 128'(round_idx[0]), 128'(0));
        check("abort_data_out",  data_out[0],        128'(0));
        repeat (3) begin
            @(negedge clk);
            check("abort_no_valid", 128'(out_valid[0]), 128'(0));
        end
        run_block(0, rnd128(), 1, 1'b0, '0);

        // Abort while idle is ignored and the block is accepted
        begin
            logic [127:0] din;
            int           cyc;
            din         = rnd128();
            abort[0]    = 1'b1;
            in_valid[0] = 1'b1;
            data_in[0]  = din;
            @(negedge clk);
            abort[0]    = 1'b0;
            in_valid[0] = 1'b0;
            check("idle_abort_accept", 128'(round_idx[0]), 128'(1));
            cyc = 1;
            while (!out_valid[0] && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("idle_abort_latency", 128'(cyc), 128'(ROUNDS + 1));
            check("idle_abort_data",    data_out[0], model(din));
            out_ready[0] = 1'b1;
            @(negedge clk);
            out_ready[0] = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
